// File: rtl/mac_8x8_accum_pkg.sv
// Shared types and constants for the 8x8 multiply-accumulate block.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int OPND_W    = 8;
    localparam int PROD_W    = 16;
    localparam int ACC_W_DEF = 24;
    localparam int LEN_W_DEF = 8;

endpackage

// File: rtl/mac_8x8_accum_mul.sv
// Combinational 8x8 unsigned array multiplier: one shifted partial product per multiplier bit.
module mac_8x8_accum_mul
    import mac_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    logic [PROD_W-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < OPND_W; i++) begin
            if (b[i]) begin
                sum = sum + (PROD_W'(a) << i);
            end
        end
    end

    assign p = sum;

endmodule

// File: rtl/mac_8x8_accum.sv
// Streamed multiply-accumulate: operand regs -> multiplier -> product reg -> accumulator,
// with a run-length FSM and a valid/ready result handshake.
module mac_8x8_accum
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic             busy
);

    localparam int SUM_W = ACC_W + 1;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [OPND_W-1:0]   a_p1_q, a_p1_d, b_p1_q, b_p1_d;
    logic                vld_p1_q, vld_p1_d;
    logic [PROD_W-1:0]   prod_p1;
    logic [PROD_W-1:0]   prod_p2_q, prod_p2_d;
    logic                vld_p2_q, vld_p2_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic [SUM_W-1:0]    sum_p3;
    logic                take;

    // Modulo-2^ACC_W add; the top bit of the result is the carry out.
    function automatic logic [SUM_W-1:0] acc_add(input logic [ACC_W-1:0] acc,
                                                 input logic [PROD_W-1:0] prod);
        return {1'b0, acc} + SUM_W'(prod);
    endfunction

    assign in_ready  = (state_q == RUN) && (cnt_q < len_q);
    assign take      = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;
    assign sum_p3    = acc_add(acc_q, prod_p2_q);

    // Stage 1 -> stage 2: multiplier between operand and product registers
    mac_8x8_accum_mul u_mul (
        .a (a_p1_q),
        .b (b_p1_q),
        .p (prod_p1)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        a_p1_d    = a_p1_q;
        b_p1_d    = b_p1_q;
        vld_p1_d  = 1'b0;
        prod_p2_d = vld_p1_q ? prod_p1 : prod_p2_q;
        vld_p2_d  = vld_p1_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;

        // Stage 3: accumulate
        if (vld_p2_q) begin
            acc_d = sum_p3[ACC_W-1:0];
            ovf_d = ovf_q | sum_p3[ACC_W];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (take) begin
                    a_p1_d   = a;
                    b_p1_d   = b;
                    vld_p1_d = 1'b1;
                    cnt_d    = cnt_q + LEN_W'(1);
                    if (cnt_d == len_q) state_d = DRAIN;
                end
            end
            // Stage 2 always empties on the edge it is seen, so only stage 1 has to be idle.
            DRAIN: begin
                if (!vld_p1_q) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
        end
    end

    // Pipeline data carries no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        a_p1_q    <= a_p1_d;
        b_p1_q    <= b_p1_d;
        prod_p2_q <= prod_p2_d;
    end

endmodule
